// File: rtl/buffer_drain_if.sv
// buffer_drain_if: groups the buffer read port and the downstream valid/ready
// bus of buffer_drain. The master side is the drain controller itself; the
// slave side is the environment (word buffer plus downstream consumer).
interface buffer_drain_if #(
    parameter int bit_width = 16,
    parameter int cnt_width = 8
);
    logic                 empty;
    logic                 consume;
    logic [bit_width-1:0] fifo_data;
    logic [bit_width-2:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [cnt_width-1:0] words_read;
    logic                 timeout;

    modport master (
        input  empty,
        input  fifo_data,
        input  out_ready,
        output consume,
        output out_data,
        output out_valid,
        output words_read,
        output timeout
    );

    modport slave (
        output empty,
        output fifo_data,
        output out_ready,
        input  consume,
        input  out_data,
        input  out_valid,
        input  words_read,
        input  timeout
    );
endinterface

// File: rtl/buffer_drain.sv
// buffer_drain: read-side controller for the dual-clock word buffer.
// Watches the buffer empty flag, issues one-cycle consume pulses, captures the
// returned word when its MSB valid flag is set and offers the payload on a
// valid/ready handshake. Only one request is ever outstanding.
// Optional feature: define BUFFER_DRAIN_TIMEOUT_EN to abandon a request after
// timeout_cycles WAIT cycles without a valid word (timeout pulses for one cycle).
module buffer_drain #(
    parameter int bit_width      = 16,
    parameter int cnt_width      = 8,
    parameter int timeout_cycles = 15
) (
    input  logic           clk,
    input  logic           rst,
    buffer_drain_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [bit_width-2:0] r_out_data;
    logic [cnt_width-1:0] r_words_read;
    logic                 w_word_valid;
    logic                 w_accept;
    logic                 w_expire;

    assign w_word_valid = bus.fifo_data[bit_width-1];
    assign w_accept     = (r_state == S_HOLD) && bus.out_ready;

`ifdef BUFFER_DRAIN_TIMEOUT_EN
    // Counter value at which the next empty WAIT cycle is the last one allowed.
    localparam logic [7:0] LP_WAIT_LAST = 8'(timeout_cycles - 1);

    logic [7:0] r_wait_cnt;
    logic       r_timeout;

    assign w_expire = (r_state == S_WAIT) && !w_word_valid && (r_wait_cnt == LP_WAIT_LAST);

    // Wait counter restarts on the REQ->WAIT edge; timeout is a registered pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (r_state == S_REQ) begin
                r_wait_cnt <= '0;
            end else if ((r_state == S_WAIT) && !w_word_valid) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    assign bus.timeout = r_timeout;
`else
    // Without the timeout feature WAIT lasts until a valid word arrives.
    logic w_unused_timeout_cfg;

    assign w_expire             = 1'b0;
    assign w_unused_timeout_cfg = ^8'(timeout_cycles);
    assign bus.timeout          = 1'b0;
`endif

    // Next-state decode of the request/wait/hold sequence.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!bus.empty) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (w_word_valid) begin
                    w_next_state = S_HOLD;
                end else if (w_expire) begin
                    w_next_state = S_IDLE;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    w_next_state = bus.empty ? S_IDLE : S_REQ;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any outstanding request or held word.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Payload capture: only a valid word seen while waiting is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data <= '0;
        end else if ((r_state == S_WAIT) && w_word_valid) begin
            r_out_data <= bus.fifo_data[bit_width-2:0];
        end
    end

    // Delivered-word counter, bumps on each accepted handshake and wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_words_read <= '0;
        end else if (w_accept) begin
            r_words_read <= r_words_read + cnt_width'(1);
        end
    end

    assign bus.consume    = (r_state == S_REQ);
    assign bus.out_valid  = (r_state == S_HOLD);
    assign bus.out_data   = r_out_data;
    assign bus.words_read = r_words_read;
endmodule

// File: doc/buffer_drain.md
# buffer_drain

Single-clock read-side controller for the dual-clock word buffer. It watches the buffer's `empty` flag and issues one-cycle `consume` pulses. It captures each returned word whose MSB valid flag is set and presents the payload downstream on a valid/ready handshake. It sits between the buffer's read port and any consumer that needs flow control, such as a packet assembler or a serialiser.

## Interface
- `bit_width`, 16, width of the buffer word; MSB is the valid flag and bits `[bit_width-2:0]` are the payload.
- `cnt_width`, 8, width of the delivered-word counter.
- `timeout_cycles`, 15, maximum WAIT cycles before abandoning a request (range 1..255).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `empty`  in  1  buffer empty flag.
- `consume`  out  1  read request to buffer; one-cycle pulse.
- `fifo_data`  in  `bit_width`  buffer output word; MSB = valid.
- `out_data`  out  `bit_width-1`  captured payload.
- `out_valid`  out  1  payload available.
- `out_ready`  in  1  downstream accepts payload.
- `words_read`  out  `cnt_width`  count of delivered words; wraps.
- `timeout`  out  1  one-cycle pulse when a request is abandoned.

## Operation
- States: IDLE, REQ, WAIT, HOLD. The state register is 2 bits.
- IDLE: if `empty`==0, go to REQ; otherwise stay.
- REQ: `consume`=1 for exactly this cycle; the next state is always WAIT.
- WAIT: if `fifo_data[bit_width-1]`==1, load `out_data` <= `fifo_data[bit_width-2:0]` and go to HOLD. Otherwise stay and increment the wait counter.
- HOLD: `out_valid`=1 and `out_data` is stable. On `out_ready`==1:
  - increment `words_read` (modulo 2^`cnt_width`);
  - go to REQ if `empty`==0, otherwise go to IDLE.
- If `out_ready`==0, stay in HOLD indefinitely.
- `consume` and `out_valid` are pure state decodes: `consume` = (state==REQ) and `out_valid` = (state==HOLD). No combinational path runs from any input to any output.
- A valid MSB seen in IDLE, REQ or HOLD is ignored. It is never captured and never counted.
- Only one request is outstanding at any time. `consume` is never asserted while in WAIT or HOLD.
- The wait counter clears on entry to WAIT.

## Timing
- Reset values: state IDLE, `consume`=0, `out_valid`=0, `out_data`=0, `words_read`=0, `timeout`=0, wait counter=0.
- `rst` asserted in any state, including mid-WAIT and mid-HOLD, takes effect at the next edge. The held payload is discarded and not counted.
- Latency from `empty` falling (sampled in IDLE) to `consume`: 1 cycle.
- `fifo_data` is sampled at the earliest in the cycle after `consume`.
- Capture to `out_valid`: `out_valid` rises on the edge that captures the word.
- Best-case throughput: one word per 3 cycles (REQ → WAIT → HOLD, with `out_ready` held at 1 and `empty` held at 0).
- In HOLD, `out_ready` and `empty` are sampled on the same edge. A buffer that turns non-empty in that cycle is serviced directly via REQ.
- `words_read` wraps from 2^`cnt_width`-1 to 0 with no flag.

## Configuration
- Macro: `BUFFER_DRAIN_TIMEOUT_EN`.
- Defined: in WAIT, after `timeout_cycles` consecutive cycles without a valid MSB, the FSM returns to IDLE. `timeout` pulses high for that one cycle, `words_read` is unchanged, and `out_data` is unchanged.
- Not defined: the wait counter is not built, WAIT waits indefinitely, and `timeout` is tied to 0.

## Test plan
- Reset: hold `rst` for 2 cycles with `empty`=0 → all outputs 0, state IDLE; first `consume` pulse occurs 1 cycle after `rst` falls.
- Single word: `empty`=0, then return `fifo_data`=0x8ABC one cycle after `consume` with `out_ready`=1 → `out_data`=0x0ABC and `out_valid`=1 for one cycle, `words_read`=1, exactly one `consume` pulse.
- Back-pressure: deliver 0x8123 with `out_ready`=0 for 10 cycles → `out_valid` stays 1, `out_data`=0x0123 stable, no further `consume`; raise `out_ready` → `words_read` increments once.
- Burst and wrap: `cnt_width`=2, `empty`=0, `out_ready`=1, 5 valid words → `consume` every 3rd cycle, `words_read` sequence 1,2,3,0,1.
- Spurious valid: drive `fifo_data` MSB=1 while in IDLE with `empty`=1 → no capture, `out_valid`=0, `words_read` unchanged.
- Timeout (macro defined, `timeout_cycles`=4): `consume` issued, `fifo_data` MSB held 0 → `timeout` pulses once 4 cycles after entering WAIT, FSM returns to IDLE, `words_read` unchanged; repeat with `rst` asserted mid-WAIT → no `timeout` pulse.
